// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory: FSM state encoding and the
// canonical NOP instruction (addi x0, x0, 0) used to fill cleared words.
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } imem_state_e;

    localparam logic [31:0] IMEM_NOP = 32'h00000013;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles little-endian load bytes into instruction words and flags when a
// word is complete, either because it is full or because the image ended.
module imem_byte_packer #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [7:0]        i_byte,
    input  logic              i_last,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_done,
    output logic              o_last_done
);

    localparam int NB = DATA_W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [DATA_W-1:0] r_buf;
    logic [IW-1:0]     r_idx;
    logic              w_full;

    assign w_full      = (r_idx == IW'(NB - 1));
    assign o_word_done = i_accept && (w_full || i_last);
    assign o_last_done = i_accept && i_last;

    // The outgoing word includes the byte arriving this cycle, so a word can be
    // written on the same edge its final byte is accepted; unfilled bytes read 0.
    always_comb begin
        o_word = '0;
        for (int k = 0; k < NB; k++) begin
            if (IW'(k) < r_idx) begin
                o_word[8*k +: 8] = r_buf[8*k +: 8];
            end else if (IW'(k) == r_idx) begin
                o_word[8*k +: 8] = i_byte;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_buf <= '0;
            r_idx <= '0;
        end else if (i_accept) begin
            if (o_word_done) begin
                r_idx <= '0;
            end else begin
                r_buf[8*r_idx +: 8] <= i_byte;
                r_idx               <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_sync.sv
// Single-port synchronous instruction memory with a NOP clear sweep after
// reset, one-cycle registered fetches, and a byte-serial program loader.
module imem_sync
    import imem_pkg::*;
#(
    parameter int                DEPTH    = 64,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(imem_pkg::IMEM_NOP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_ovf,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);

    imem_state_e       r_state;
    imem_state_e       w_next_state;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_clr_idx;
    logic [AW:0]       r_ptr;
    logic              r_ovf;
    logic              r_fetch_valid;
    logic              r_fetch_err;
    logic [DATA_W-1:0] r_fetch_data;

    logic [AW-1:0]     w_fetch_idx;
    logic              w_fetch_bad;
    logic              w_start;
    logic              w_accept;
    logic              w_ptr_full;
    logic [DATA_W-1:0] w_pack_word;
    logic              w_word_done;
    logic              w_last_done;
    logic              w_mem_we;
    logic [AW-1:0]     w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_fetch_idx = fetch_addr[AW+1:2];
    assign w_fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:AW+2] != '0);
    assign w_start     = (r_state == RUN) && ld_start;
    assign w_accept    = ld_valid && (r_state == LOAD);
    assign w_ptr_full  = (r_ptr == (AW+1)'(DEPTH));

    imem_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clear     (w_start),
        .i_accept    (w_accept),
        .i_byte      (ld_byte),
        .i_last      (ld_last),
        .o_word      (w_pack_word),
        .o_word_done (w_word_done),
        .o_last_done (w_last_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CLEAR:   if (r_clr_idx == AW'(DEPTH - 1)) w_next_state = RUN;
            RUN:     if (ld_start)                    w_next_state = LOAD;
            LOAD:    if (w_last_done)                 w_next_state = RUN;
            default:                                  w_next_state = CLEAR;
        endcase
    end

    // One shared RAM port: CLEAR and LOAD only write, RUN only reads.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = w_fetch_idx;
        w_mem_wdata = w_pack_word;
        case (r_state)
            CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_idx;
                w_mem_wdata = NOP_WORD;
            end
            LOAD: begin
                w_mem_we   = w_word_done && !w_ptr_full;
                w_mem_addr = r_ptr[AW-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign w_mem_rdata = r_mem[w_mem_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_idx     <= '0;
            r_ptr         <= '0;
            r_ovf         <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_fetch_data  <= NOP_WORD;
        end else begin
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                end
                RUN: begin
                    if (fetch_req) begin
                        r_fetch_valid <= 1'b1;
                        r_fetch_err   <= w_fetch_bad;
                        r_fetch_data  <= w_fetch_bad ? NOP_WORD : w_mem_rdata;
                    end
                    if (ld_start) begin
                        r_ptr <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                LOAD: begin
                    // The pointer saturates at DEPTH; anything beyond is dropped.
                    if (w_word_done) begin
                        if (w_ptr_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign fetch_err   = r_fetch_err;
    assign fetch_data  = r_fetch_data;
    assign ld_ready    = (r_state == LOAD);
    assign ld_ovf      = r_ovf;
    assign busy        = (r_state != RUN);

endmodule

// File: doc/imem_sync.md
IMEM_SYNC -- requirements
Module: imem_sync

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of instruction words; it must be a power of two and at least 4.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the instruction width in bits; it must be a multiple of 8.
REQ-003 The block SHALL have parameter NOP_WORD, default 32'h00000013, meaning the fill value used by the clear sweep.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port fetch_req, input, 1 bit: fetch request.
REQ-007 The block SHALL have port fetch_addr, input, 32 bits: fetch byte address.
REQ-008 The block SHALL have port fetch_valid, output, 1 bit: fetch_data and fetch_err are valid this cycle.
REQ-009 The block SHALL have port fetch_data, output, DATA_W bits: the fetched instruction.
REQ-010 The block SHALL have port fetch_err, output, 1 bit: the fetch address was misaligned or out of range.
REQ-011 The block SHALL have port ld_start, input, 1 bit: one-cycle pulse that opens a program load.
REQ-012 The block SHALL have port ld_valid, input, 1 bit: ld_byte is valid.
REQ-013 The block SHALL have port ld_byte, input, 8 bits: load data, little-endian within each word.
REQ-014 The block SHALL have port ld_last, input, 1 bit: marks the final byte of the image.
REQ-015 The block SHALL have port ld_ready, output, 1 bit: the block accepts a load byte.
REQ-016 The block SHALL have port ld_ovf, output, 1 bit: sticky flag, image exceeded DEPTH words.
REQ-017 The block SHALL have port busy, output, 1 bit: state is not RUN.

Function
REQ-018 The block SHALL implement the FSM states CLEAR, RUN and LOAD.
REQ-019 In CLEAR, the block SHALL write NOP_WORD to one word per cycle, from 0 to DEPTH-1, then enter RUN, taking exactly DEPTH cycles.
REQ-020 In RUN, a cycle with fetch_req=1 at edge N SHALL produce fetch_valid=1 at edge N+1, with fetch_data=mem[fetch_addr[log2(DEPTH)+1:2]] registered; the read latency is 1.
REQ-021 When fetch_req=0 at edge N, fetch_valid SHALL be 0 at edge N+1, and fetch_data SHALL hold its last value.
REQ-022 fetch_err SHALL be 1 with fetch_valid when fetch_addr[1:0]!=0 or fetch_addr>=4*DEPTH; fetch_data SHALL then be NOP_WORD.
REQ-023 In CLEAR and LOAD, the block SHALL ignore fetch_req and hold fetch_valid at 0.
REQ-024 In RUN, ld_start=1 SHALL move the FSM to LOAD on the next edge, clearing the word pointer, the byte index and ld_ovf.
REQ-025 If ld_start and fetch_req are asserted in the same RUN cycle, the fetch SHALL complete, and the FSM SHALL be in LOAD afterwards.
REQ-026 ld_ready SHALL be 1 only in LOAD; a byte is accepted on any edge where ld_valid&&ld_ready.
REQ-027 Accepted bytes SHALL be assembled LSB-first into a DATA_W/8-byte shift buffer; when the buffer is complete, the block SHALL write it to mem[ptr] and increment ptr.
REQ-028 On an accepted ld_last with a partial word, the block SHALL write that word with the unfilled upper bytes zero.
REQ-029 After the accepted ld_last has been processed, the FSM SHALL return to RUN.
REQ-030 Once ptr==DEPTH, further complete words SHALL be dropped, ld_ovf SHALL be set, and ptr SHALL NOT wrap.
REQ-031 Words not written during a load SHALL keep their previous contents.
REQ-032 ld_start asserted in CLEAR or LOAD SHALL be ignored.

Reset
REQ-033 reset SHALL be sampled on a clk edge; it overrides all other inputs.
REQ-034 On reset, the FSM SHALL enter CLEAR, ptr and the byte index SHALL be cleared to 0, and fetch_valid=0, fetch_err=0, fetch_data=NOP_WORD, ld_ready=0, ld_ovf=0, busy=1.
REQ-035 A reset during LOAD SHALL abandon the partial buffer and rerun the full CLEAR sweep.

Structure
REQ-036 Shared package imem_pkg SHALL hold the FSM state enum (CLEAR, RUN, LOAD) and the NOP constant 32'h00000013.
REQ-037 The block SHALL contain one sub-module, imem_byte_packer, containing the byte shift buffer, the byte index, and word-complete/last flags.
REQ-038 The memory array SHALL be a single-port synchronous RAM; a write and a read never occur in the same state.

Verification
REQ-039 Bench: reset, wait 64 cycles, fetch 0x00 and 0xFC -> busy falls exactly at cycle 64; both fetches return 0x00000013 one cycle after request, fetch_err=0.
REQ-040 Bench: load 8 bytes 13 05 50 00 93 05 75 00 with ld_last on the final byte, then fetch 0x0 and 0x4 -> 0x00500513 and 0x00750593; fetch 0x8 -> 0x00000013.
REQ-041 Bench: fetch 0x2 and 0x100 (DEPTH=64) -> fetch_valid=1, fetch_err=1, fetch_data=0x00000013.
REQ-042 Bench: load 3 bytes EF 00 80 with ld_last -> mem[0]=0x008000EF.
REQ-043 Bench: load 65 words -> ld_ovf=1, mem[63] holds word 63, FSM returns to RUN.
REQ-044 Bench: reset after 5 load bytes -> busy=1 for 64 cycles, then fetch 0x0 returns 0x00000013.
